traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised N-approach traffic-light sequencer. It is the successor of the two-way controller in the `Problem2` design. Each approach has its own green time, with shared yellow and all-red times. Rotation skips approaches whose mask bit is set, and a flash mode is added. Runs in the single system clock domain, advanced by a one-cycle `tick_i` strobe. Duration adjust commands arrive as clean single-cycle pulses, already debounced upstream.

## Interface
- `N_APPR`, 2: number of approaches, 2..8.
- `TIME_W`, 4: countdown/duration width.
- `DEF_G`, 5: reset green length, all approaches.
- `DEF_Y`, 2: reset yellow length.
- `DEF_R`, 1: reset all-red length.
- `clk_i` in 1: system clock, the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `tick_i` in 1: one-cycle time-base strobe (1 Hz nominal).
- `mode_i` in 2: 0 NORMAL, 1 ADJ, 2 FLASH, 3 treated as NORMAL.
- `adj_idx_i` in `IDX_W=$clog2(N_APPR+2)`: duration selector. 0..N-1 are green[k], N is yellow, N+1 is all-red.
- `cmd_inc_i`, `cmd_dec_i`, `cmd_def_i` in 1 each: adjust pulses, honoured only in ADJ.
- `skip_i` in `N_APPR`: bit k set means approach k is skipped in rotation.
- `light_o` out `2*N_APPR`: 2-bit code per approach, k at [2k+1:2k]. Codes: 00 off, 01 red, 10 yellow, 11 green.
- `time_o` out `TIME_W`: display value.
- `phase_o` out `$clog2(N_APPR)`: current approach index.
- `stage_o` out 2: 0 GREEN, 1 YELLOW, 2 ALLRED, 3 FLASH.

## Operation
- **Stage FSM**
  - GREEN -> YELLOW, loads Y.
  - YELLOW -> ALLRED, loads R.
  - ALLRED -> GREEN of next unmasked approach, loads green[next].
  - Each transition fires on a tick with cnt==0. Otherwise a tick decrements cnt.
  - A stage therefore lasts len+1 ticks.
- **Next approach**
  - Search p+1, p+2, … modulo N for the first bit with skip_i==0. Search includes p itself last.
  - If all approaches are masked: stay in ALLRED, reload R, phase unchanged.
- **Mask change mid-green**: no effect until the next ALLRED exit.
- **Lights in NORMAL/ADJ**
  - Approach p shows green or yellow per stage.
  - All other approaches show red; in ALLRED every approach is red.
- **ADJ mode**
  - Sequencing continues unchanged.
  - `time_o` shows the selected duration register.
  - Priority: inc > dec > def when pulses coincide.
  - inc saturates at 2^TIME_W-1; dec saturates at 0; def restores the parameter default.
  - `adj_idx_i` > N+1: commands ignored and `time_o`=0.
- **Duration loads**: a load uses the register value before any same-cycle edit. Edits take effect at the next load.
- **FLASH entry**
  - Stage becomes FLASH, sequencing halts, flash bit set to 1.
  - Each tick toggles the flash bit.
  - Lights: all approaches yellow when the bit is 1, off when 0.
  - `time_o`=0.
- **FLASH exit (mode leaves FLASH)**: enter ALLRED, load R, phase unchanged. Rotation resumes from that phase.
- **NORMAL display**: `time_o` = cnt.

## Timing
- **Reset** (effective at the first edge with `rst_i`=1):
  - Stage GREEN, phase 0, cnt=`DEF_G`.
  - All durations at defaults, flash bit 0.
  - `light_o`: approach 0 = 11, others = 01.
  - `time_o`=`DEF_G`, `phase_o`=0, `stage_o`=0.
- Reset overrides tick and commands in the same cycle.
- **Output registering**: all outputs are registered. A tick or mode change at edge n is visible after edge n+1 (1-cycle latency).
- **Adjust edits**: an edit at edge n shows on `time_o` after edge n+1.
- **Mode change with tick in the same cycle**:
  - Into FLASH: the mode change wins and the tick is ignored.
  - Out of FLASH: the ALLRED load happens and the tick is ignored.
- **Unbounded tick spacing**: ≥1 cycle apart. Back-to-back ticks are each counted.

## Structure
- **`traffic_pkg`** holds:
  - light codes (`LIGHT_OFF/RED/YEL/GRN`)
  - mode encoding
  - stage encoding
  - the index-width helper function
- **`dur_regfile`** sub-module owns the N+2 duration registers:
  - saturating inc/dec/def logic
  - combinational read port for the load mux
  - separate read port for the display
- **`traffic_phase_ctrl`** top holds the FSM, countdown, skip search, flash bit and output registers.

## Test plan
- N=2, defaults G5/Y2/R1, NORMAL, ticks only -> approach 0 green for 6 ticks, yellow 3, all-red 2. Approach 1 goes green at tick 11 with `time_o`=5.
- ADJ, idx=1, three inc pulses during approach 0 green -> `time_o`=8. Approach 1 green then lasts 9 ticks. Inc from 15 stays 15; dec from 0 stays 0; def restores 5.
- N=4, skip_i=4'b0110 -> phase sequence 0,3,0,3. skip_i=4'b1111 -> stays ALLRED, reloading R each 2 ticks, phase frozen.
- FLASH mid-yellow -> stage 3; lights toggle all-10 / all-00 per tick. Exit -> ALLRED with `time_o`=1, then the next approach goes green.
- inc and dec asserted together -> inc applied. Mode=3 -> behaves as NORMAL. `adj_idx_i`=N+2 -> commands ignored, `time_o`=0.
- `rst_i` asserted mid-yellow with `tick_i` high -> next cycle shows reset values above and no decrement.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light codes, mode/stage encodings and index-width helper
package traffic_pkg;
   localparam logic [1:0] LIGHT_OFF = 2'b00;
   localparam logic [1:0] LIGHT_RED = 2'b01;
   localparam logic [1:0] LIGHT_YEL = 2'b10;
   localparam logic [1:0] LIGHT_GRN = 2'b11;
   typedef enum logic [1:0] {MODE_NORMAL, MODE_ADJ, MODE_FLASH, MODE_ALT} mode_t;
   typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED, ST_FLASH} stage_t;
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/dur_regfile.sv
// dur_regfile: N green durations plus shared yellow and all-red, with saturating edits
module dur_regfile import traffic_pkg::*; #(
   parameter int N_APPR = 2,
   parameter int TIME_W = 4,
   parameter int DEF_G  = 5,
   parameter int DEF_Y  = 2,
   parameter int DEF_R  = 1,
   parameter int IDX_W  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en,
   input  logic [IDX_W-1:0]  adj_idx,
   input  logic              inc,
   input  logic              dec,
   input  logic              def,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [TIME_W-1:0] rd_val,
   output logic [TIME_W-1:0] disp_val
);
   logic [TIME_W-1:0] dur [N_APPR+2];
   function automatic logic [TIME_W-1:0] def_of(input int k);
      return k < N_APPR ? TIME_W'(DEF_G) : k == N_APPR ? TIME_W'(DEF_Y) : TIME_W'(DEF_R);
   endfunction
   always_ff @(posedge clk_i)
      for (int k = 0; k < N_APPR + 2; k++)
         if (rst_i)
            dur[k] <= def_of(k);
         else if (en && int'(adj_idx) == k)
            dur[k] <= inc ? (&dur[k] ? dur[k] : dur[k] + 1'b1) :
                      dec ? (|dur[k] ? dur[k] - 1'b1 : dur[k]) :
                      def ? def_of(k) : dur[k];
   assign rd_val   = int'(rd_idx) < N_APPR + 2 ? dur[rd_idx] : '0;
   assign disp_val = int'(adj_idx) < N_APPR + 2 ? dur[adj_idx] : '0;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach light sequencer with skip mask, duration adjust and flash mode
module traffic_phase_ctrl import traffic_pkg::*; #(
   parameter  int N_APPR = 2,
   parameter  int TIME_W = 4,
   parameter  int DEF_G  = 5,
   parameter  int DEF_Y  = 2,
   parameter  int DEF_R  = 1,
   localparam int IDX_W  = idx_w(N_APPR + 2),
   localparam int PW     = idx_w(N_APPR)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                tick_i,
   input  logic [1:0]          mode_i,
   input  logic [IDX_W-1:0]    adj_idx_i,
   input  logic                cmd_inc_i,
   input  logic                cmd_dec_i,
   input  logic                cmd_def_i,
   input  logic [N_APPR-1:0]   skip_i,
   output logic [2*N_APPR-1:0] light_o,
   output logic [TIME_W-1:0]   time_o,
   output logic [PW-1:0]       phase_o,
   output logic [1:0]          stage_o
);
   stage_t            stage, stage_n;
   mode_t             mode_q;
   logic [PW-1:0]     phase, phase_n, nxt, c;
   logic [TIME_W-1:0] cnt, cnt_n, rd_val, disp_val;
   logic [IDX_W-1:0]  rd_idx;
   logic              flash, flash_n, found, flash_mode;
   assign flash_mode = mode_i == MODE_FLASH;
   dur_regfile #(
      .N_APPR(N_APPR), .TIME_W(TIME_W), .DEF_G(DEF_G), .DEF_Y(DEF_Y), .DEF_R(DEF_R), .IDX_W(IDX_W)
   ) u_dur (
      .clk_i(clk_i), .rst_i(rst_i), .en(mode_i == MODE_ADJ), .adj_idx(adj_idx_i),
      .inc(cmd_inc_i), .dec(cmd_dec_i), .def(cmd_def_i),
      .rd_idx(rd_idx), .rd_val(rd_val), .disp_val(disp_val)
   );
   function automatic logic [2*N_APPR-1:0] lights_of(input stage_t s, input logic [PW-1:0] p, input logic f);
      logic [2*N_APPR-1:0] l;
      for (int k = 0; k < N_APPR; k++)
         l[2*k +: 2] = s == ST_FLASH ? (f ? LIGHT_YEL : LIGHT_OFF) :
                       (k != int'(p) || s == ST_ALLRED) ? LIGHT_RED :
                       s == ST_GREEN ? LIGHT_GRN : LIGHT_YEL;
      return l;
   endfunction
   // descending scan so the nearest unmasked successor (p itself last) wins
   always_comb begin
      nxt   = phase;
      found = 1'b0;
      c     = '0;
      for (int i = N_APPR; i >= 1; i--) begin
         c = PW'((int'(phase) + i) % N_APPR);
         if (!skip_i[c]) begin
            nxt   = c;
            found = 1'b1;
         end
      end
   end
   // yellow load from GREEN; all-red reload covers YELLOW, masked ALLRED and flash exit
   assign rd_idx = stage == ST_GREEN ? IDX_W'(N_APPR) :
                   (stage == ST_ALLRED && found) ? IDX_W'(nxt) : IDX_W'(N_APPR + 1);
   always_comb begin
      stage_n = stage;
      phase_n = phase;
      cnt_n   = cnt;
      flash_n = flash;
      if (stage == ST_FLASH) begin
         if (!flash_mode) begin
            stage_n = ST_ALLRED;
            cnt_n   = rd_val;
         end else if (tick_i)
            flash_n = ~flash;
      end else if (flash_mode) begin
         stage_n = ST_FLASH;
         flash_n = 1'b1;
      end else if (tick_i && cnt != '0)
         cnt_n = cnt - 1'b1;
      else if (tick_i) begin
         cnt_n   = rd_val;
         stage_n = stage == ST_GREEN ? ST_YELLOW : stage == ST_YELLOW ? ST_ALLRED :
                   found ? ST_GREEN : ST_ALLRED;
         phase_n = (stage == ST_ALLRED && found) ? nxt : phase;
      end
   end
   always_ff @(posedge clk_i)
      if (rst_i) begin
         stage   <= ST_GREEN;
         phase   <= '0;
         cnt     <= TIME_W'(DEF_G);
         flash   <= 1'b0;
         mode_q  <= MODE_NORMAL;
         light_o <= lights_of(ST_GREEN, '0, 1'b0);
         time_o  <= TIME_W'(DEF_G);
         phase_o <= '0;
         stage_o <= ST_GREEN;
      end else begin
         stage   <= stage_n;
         phase   <= phase_n;
         cnt     <= cnt_n;
         flash   <= flash_n;
         mode_q  <= mode_t'(mode_i);
         light_o <= lights_of(stage, phase, flash);
         time_o  <= stage == ST_FLASH ? '0 : mode_q == MODE_ADJ ? disp_val : cnt;
         phase_o <= phase;
         stage_o <= stage;
      end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed checks of sequencing, adjust, skip and flash on N=2 and N=4 instances
module tb_traffic_phase_ctrl;
   bit         clk;
   logic       rst = 1'b1, tick = 1'b0, inc = 1'b0, dec = 1'b0, def = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [1:0] idx2 = 2'd0, skip2 = 2'b00;
   logic [2:0] idx4 = 3'd0;
   logic [3:0] skip4 = 4'b0000;
   logic [3:0] light2, time2, time4;
   logic [7:0] light4;
   logic [0:0] phase2;
   logic [1:0] phase4, stage2, stage4;
   int         tests = 0, fails = 0;
   always #5 clk = ~clk;
   traffic_phase_ctrl #(.N_APPR(2)) u2 (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .mode_i(mode), .adj_idx_i(idx2),
      .cmd_inc_i(inc), .cmd_dec_i(dec), .cmd_def_i(def), .skip_i(skip2),
      .light_o(light2), .time_o(time2), .phase_o(phase2), .stage_o(stage2)
   );
   traffic_phase_ctrl #(.N_APPR(4)) u4 (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .mode_i(mode), .adj_idx_i(idx4),
      .cmd_inc_i(inc), .cmd_dec_i(dec), .cmd_def_i(def), .skip_i(skip4),
      .light_o(light4), .time_o(time4), .phase_o(phase4), .stage_o(stage4)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tk(input int n);
      repeat (n) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         @(negedge clk);
      end
   endtask
   task automatic pulse(input logic i, input logic d, input logic f);
      inc = i; dec = d; def = f;
      @(negedge clk);
      inc = 1'b0; dec = 1'b0; def = 1'b0;
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      tick = 1'b1;
      @(negedge clk);
      rst = 1'b0; tick = 1'b0;
      chk("rst_light2", light2, 4'b0111);
      chk("rst_time2", time2, 5);
      chk("rst_phase2", phase2, 0);
      chk("rst_stage2", stage2, 0);
      chk("rst_light4", light4, 8'b01010111);
      // normal rotation, N=2
      tk(5);
      chk("g0_end_time", time2, 0);
      chk("g0_end_stage", stage2, 0);
      tk(1);
      chk("y0_stage", stage2, 1);
      chk("y0_time", time2, 2);
      chk("y0_light", light2, 4'b0110);
      tk(3);
      chk("ar_stage", stage2, 2);
      chk("ar_time", time2, 1);
      chk("ar_light", light2, 4'b0101);
      tk(2);
      chk("g1_stage", stage2, 0);
      chk("g1_phase", phase2, 1);
      chk("g1_time", time2, 5);
      chk("g1_light", light2, 4'b1101);
      // adjust green[1] to 8
      do_reset();
      mode = 2'd1; idx2 = 2'd1;
      repeat (3) pulse(1, 0, 0);
      chk("adj_inc3", time2, 8);
      chk("adj_stage", stage2, 0);
      mode = 2'd0;
      tk(11);
      chk("adj_g1_phase", phase2, 1);
      chk("adj_g1_time", time2, 8);
      tk(8);
      chk("adj_g1_last_time", time2, 0);
      chk("adj_g1_last_stage", stage2, 0);
      tk(1);
      chk("adj_g1_to_y", stage2, 1);
      mode = 2'd1;
      repeat (7) pulse(1, 0, 0);
      chk("adj_at15", time2, 15);
      pulse(1, 0, 0);
      chk("adj_sat_hi", time2, 15);
      pulse(0, 0, 1);
      chk("adj_def", time2, 5);
      repeat (5) pulse(0, 1, 0);
      chk("adj_at0", time2, 0);
      pulse(0, 1, 0);
      chk("adj_sat_lo", time2, 0);
      pulse(1, 1, 0);
      chk("adj_inc_beats_dec", time2, 1);
      pulse(0, 1, 1);
      chk("adj_dec_beats_def", time2, 0);
      idx2 = 2'd2;
      @(negedge clk);
      chk("adj_show_y", time2, 2);
      idx2 = 2'd3;
      @(negedge clk);
      chk("adj_show_r", time2, 1);
      // mode 3 acts as NORMAL
      mode = 2'd3;
      do_reset();
      tk(6);
      chk("m3_stage", stage2, 1);
      chk("m3_time", time2, 2);
      // flash entered mid-yellow with a coincident tick
      tk(1);
      mode = 2'd2; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("fl_stage", stage2, 3);
      chk("fl_light_on", light2, 4'b1010);
      chk("fl_time", time2, 0);
      tk(1);
      chk("fl_light_off", light2, 4'b0000);
      tk(1);
      chk("fl_light_on2", light2, 4'b1010);
      mode = 2'd0; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("flx_stage", stage2, 2);
      chk("flx_time", time2, 1);
      chk("flx_phase", phase2, 0);
      chk("flx_light", light2, 4'b0101);
      tk(1);
      chk("flx_dec", time2, 0);
      tk(1);
      chk("flx_g_stage", stage2, 0);
      chk("flx_g_phase", phase2, 1);
      chk("flx_g_time", time2, 5);
      // skip mask on N=4
      skip4 = 4'b0110;
      do_reset();
      chk("sk_phase_a", phase4, 0);
      tk(11);
      chk("sk_phase_b", phase4, 3);
      chk("sk_stage_b", stage4, 0);
      tk(11);
      chk("sk_phase_c", phase4, 0);
      tk(11);
      chk("sk_phase_d", phase4, 3);
      skip4 = 4'b1111;
      tk(11);
      chk("all_stage", stage4, 2);
      chk("all_time", time4, 1);
      chk("all_phase", phase4, 3);
      chk("all_light", light4, 8'b01010101);
      tk(2);
      chk("all_stage2", stage4, 2);
      chk("all_time2", time4, 1);
      chk("all_phase2", phase4, 3);
      // out-of-range adjust index on N=4
      mode = 2'd1; idx4 = 3'd6;
      @(negedge clk);
      @(negedge clk);
      chk("oor_time", time4, 0);
      pulse(1, 0, 0);
      pulse(0, 0, 1);
      chk("oor_time2", time4, 0);
      idx4 = 3'd4;
      @(negedge clk);
      chk("oor_y_kept", time4, 2);
      idx4 = 3'd5;
      @(negedge clk);
      chk("oor_r_kept", time4, 1);
      idx4 = 3'd0;
      @(negedge clk);
      chk("oor_g0_kept", time4, 5);
      // reset mid-yellow with a coincident tick
      mode = 2'd0;
      do_reset();
      tk(7);
      chk("pre_rst_stage", stage2, 1);
      chk("pre_rst_time", time2, 1);
      rst = 1'b1; tick = 1'b1;
      @(negedge clk);
      rst = 1'b0; tick = 1'b0;
      chk("mrst_stage", stage2, 0);
      chk("mrst_time", time2, 5);
      chk("mrst_phase", phase2, 0);
      chk("mrst_light", light2, 4'b0111);
      @(negedge clk);
      chk("mrst_no_dec", time2, 5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
